operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage that sits directly upstream of the 32 x 32-bit register file. It accepts decoded instructions over a valid/ready handshake, drives both register-file read ports, and bypasses same-cycle writeback data. A 32-entry scoreboard of pending writes stalls RAW/WAW hazards. It presents registered operands to the execute stage one cycle after acceptance.

## Interface
- DATA_W, 32, register/operand width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- STALL_W, 16, stall counter width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs, in_rt  in  ADDR_W  source register addresses
- in_rd  in  ADDR_W  destination register address
- in_we  in  1  instruction writes in_rd
- rf_rdAddrA, rf_rdAddrB  out  ADDR_W  register-file read addresses (= in_rs, in_rt, combinational)
- rf_rdDataA, rf_rdDataB  in  DATA_W  register-file read data (combinational read)
- wb_valid  in  1  writeback from downstream this cycle
- wb_addr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- rf_write, rf_wrAddr, rf_wrData  out  1/ADDR_W/DATA_W  register-file write port (combinational: rf_write = wb_valid && wb_addr != 0)
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_opA, out_opB  out  DATA_W  operand values
- out_rd  out  ADDR_W  destination
- out_we  out  1  write enable carried forward
- stall_cnt  out  STALL_W  cycles with in_valid && !in_ready, saturating

## Operation
- Register 0 reads as 0 and is never marked pending. Writes to it are dropped (rf_write = 0).
- Operand select per source s: if s == 0 -> 0; else if wb_valid && wb_addr == s -> wb_data (bypass); else the rf read data.
- Source ready: s == 0, or !pending[s], or (wb_valid && wb_addr == s).
- Dest ready: !in_we, or in_rd == 0, or !pending[in_rd], or (wb_valid && wb_addr == in_rd).
- hazard = !(srcA ready && srcB ready && dest ready).
- slot_free = !out_valid || out_ready.
- in_ready = !hazard && slot_free. It is combinational from in_* and wb_*, with no dependence on in_valid.
- accept = in_valid && in_ready. On accept, the output register loads the selected operands plus in_rd and in_we, and out_valid is set to 1.
- If out_valid && out_ready && !accept, out_valid is cleared to 0.
- Scoreboard per cycle: clear pending[wb_addr] when wb_valid; set pending[in_rd] on accept with in_we && in_rd != 0.
- Simultaneous set and clear of the same address: set wins.
- stall_cnt increments when in_valid && !in_ready. It saturates at all-ones and does not wrap.

## Timing
- Reset (reset == 0 at clk edge): out_valid = 0; out_opA = out_opB = 0; out_rd = 0; out_we = 0; all pending = 0; stall_cnt = 0. Reset overrides any accept or writeback in the same cycle.
- in_ready is held low while reset == 0.
- Latency: an instruction accepted at edge N appears on out_* with out_valid = 1 after edge N.
- Output holds stable while out_valid && !out_ready.
- Full throughput: one accept per cycle when there are no hazards and out_ready == 1.
- A pending source is released in the same cycle its writeback arrives, through the bypass. There is no extra bubble.
- Write-after-write to a pending rd stalls until that rd's writeback cycle.

## Structure
- Shared package holds DATA_W, ADDR_W, NUM_REGS = 2^ADDR_W, and the zero-register constant.
- Sub-module of_scoreboard holds the NUM_REGS pending bits with set/clear ports, set priority, and bit 0 tied to 0. The top level holds the bypass muxes, hazard logic, output register and stall counter.

## Test plan
- Reset, then issue rs=1, rt=2, rd=3, we=1 with rf data 0x11/0x22 and out_ready=1. Required: out_opA=0x11, out_opB=0x22 one cycle later, and pending[3]=1.
- Issue rd=5 we=1, then the next instruction with rs=5 and no writeback. Required: in_ready=0 and stall_cnt increments each cycle. When wb_valid, wb_addr=5, wb_data=0xDEADBEEF arrives, the instruction is accepted that cycle with out_opA=0xDEADBEEF, and pending[5]=0.
- rs=0, rt=0, with rf data forced to 0xFFFFFFFF and wb to addr 0. Required: operands 0, rf_write=0, no stall.
- Hold out_ready=0 for 3 cycles with in_valid=1. Required: out_* stable, in_ready=0, and one accept occurs the cycle out_ready rises.
- Same cycle: wb clears rd=7 while accepting a new instruction with rd=7 we=1. Required: pending[7]=1 afterwards.
- Drive reset=0 mid-stall with out_valid=1 and several pending bits set. Required: all outputs and scoreboard reach their reset values after one edge, and stall_cnt=0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage and its scoreboard.
package operand_fetch_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int STALL_W  = 16;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Architectural zero register: always reads 0, never pending, never written.
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per register, set has priority over clear,
// and bit 0 is permanently clear.
module of_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_pending
);

  logic [NUM_REGS-1:0] r_pending;

  // Per-register update; a new writer marking the same register as a retiring
  // writeback leaves it pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set && i_set_addr == ADDR_W'(i)) begin
          r_pending[i] <= 1'b1;
        end else if (i_clr && i_clr_addr == ADDR_W'(i)) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads both register-file ports, bypasses same-cycle
// writeback, stalls on RAW/WAW hazards and registers operands for execute.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready never depends on in_valid; out_* hold stable while
// out_valid && !out_ready.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_rs,
  input  logic [ADDR_W-1:0]  in_rt,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic               in_we,
  output logic [ADDR_W-1:0]  rf_rdAddrA,
  output logic [ADDR_W-1:0]  rf_rdAddrB,
  input  logic [DATA_W-1:0]  rf_rdDataA,
  input  logic [DATA_W-1:0]  rf_rdDataB,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               rf_write,
  output logic [ADDR_W-1:0]  rf_wrAddr,
  output logic [DATA_W-1:0]  rf_wrData,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_opA,
  output logic [DATA_W-1:0]  out_opB,
  output logic [ADDR_W-1:0]  out_rd,
  output logic               out_we,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [NUM_REGS-1:0] w_pending;
  logic                w_byp_a, w_byp_b, w_byp_d;
  logic [DATA_W-1:0]   w_op_a, w_op_b;
  logic                w_src_a_rdy, w_src_b_rdy, w_dst_rdy;
  logic                w_hazard, w_slot_free, w_accept, w_set;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_op_a, r_out_op_b;
  logic [ADDR_W-1:0]   r_out_rd;
  logic                r_out_we;
  logic [STALL_W-1:0]  r_stall;

  assign rf_rdAddrA = in_rs;
  assign rf_rdAddrB = in_rt;

  assign rf_write  = wb_valid && (wb_addr != ZERO_REG);
  assign rf_wrAddr = wb_addr;
  assign rf_wrData = wb_data;

  // Operand select and hazard detection; a writeback arriving this cycle
  // releases its register immediately through the bypass.
  always_comb begin
    w_byp_a     = wb_valid && (wb_addr == in_rs);
    w_byp_b     = wb_valid && (wb_addr == in_rt);
    w_byp_d     = wb_valid && (wb_addr == in_rd);
    w_op_a      = (in_rs == ZERO_REG) ? '0 : (w_byp_a ? wb_data : rf_rdDataA);
    w_op_b      = (in_rt == ZERO_REG) ? '0 : (w_byp_b ? wb_data : rf_rdDataB);
    w_src_a_rdy = (in_rs == ZERO_REG) || !w_pending[in_rs] || w_byp_a;
    w_src_b_rdy = (in_rt == ZERO_REG) || !w_pending[in_rt] || w_byp_b;
    w_dst_rdy   = !in_we || (in_rd == ZERO_REG) || !w_pending[in_rd] || w_byp_d;
    w_hazard    = !(w_src_a_rdy && w_src_b_rdy && w_dst_rdy);
    w_slot_free = !r_out_valid || out_ready;
    in_ready    = reset && !w_hazard && w_slot_free;
    w_accept    = in_valid && in_ready;
    w_set       = w_accept && in_we && (in_rd != ZERO_REG);
  end

  of_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set      (w_set),
    .i_set_addr (in_rd),
    .i_clr      (wb_valid),
    .i_clr_addr (wb_addr),
    .o_pending  (w_pending)
  );

  // Output register: load on accept, drop valid once execute takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_op_a  <= '0;
      r_out_op_b  <= '0;
      r_out_rd    <= '0;
      r_out_we    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_op_a  <= w_op_a;
      r_out_op_b  <= w_op_b;
      r_out_rd    <= in_rd;
      r_out_we    <= in_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held off.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (in_valid && !in_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_opA   = r_out_op_a;
  assign out_opB   = r_out_op_b;
  assign out_rd    = r_out_rd;
  assign out_we    = r_out_we;
  assign stall_cnt = r_stall;

endmodule
